// File: rtl/router_pkg.sv
// Shared types, constants and header helper for the router packet framer.
package router_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HDR,
        PAY,
        PAR,
        GAP
    } framer_state_t;

    localparam int         ROUTER_MAX_LEN      = 63;
    localparam int         ROUTER_LEN_W        = 6;
    localparam logic [1:0] ROUTER_ILLEGAL_DEST = 2'd3;

    // Router header byte: length in the upper six bits, destination in the low two.
    function automatic logic [7:0] make_header(input logic [5:0] len, input logic [1:0] dest);
        return {len, dest};
    endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// Payload buffer: single-clock RAM with one write port and a combinational read port.
module router_pkt_buf
    import router_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = ROUTER_MAX_LEN,
    parameter int AW     = ROUTER_LEN_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/router_pkt_framer.sv
// Packet framer feeding the 1x3 router: buffers a payload, then sends header,
// payload and parity. Optional macro ROUTER_PARITY_INJ_EN adds inj_err to corrupt parity.
module router_pkt_framer
    import router_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_LEN  = ROUTER_MAX_LEN,
    parameter int IDLE_GAP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        dest,
    input  logic [5:0]        len,
`ifdef ROUTER_PARITY_INJ_EN
    input  logic              inj_err,
`endif
    output logic              ready,
    input  logic [DATA_W-1:0] pl_data,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic              busy,
    output logic [DATA_W-1:0] data,
    output logic              pkt_valid,
    output logic              done,
    output logic              cfg_err,
    output logic [2:0]        dbg_state
);

    framer_state_t     r_state,  w_state;
    logic [DATA_W-1:0] r_data,   w_data;
    logic              r_pkt_valid, w_pkt_valid;
    logic              r_done,   w_done;
    logic              r_cfg_err, w_cfg_err;
    logic [5:0]        r_len,    w_len;
    logic [1:0]        r_dest,   w_dest;
    logic [5:0]        r_wr_idx, w_wr_idx;
    logic [5:0]        r_rd_idx, w_rd_idx;
    logic [3:0]        r_gap_cnt, w_gap_cnt;
    logic [DATA_W-1:0] r_parity, w_parity;
    logic              r_inj,    w_inj;
    logic              w_inj_in;
    logic              w_buf_we;
    logic [5:0]        w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;

`ifdef ROUTER_PARITY_INJ_EN
    assign w_inj_in = inj_err;
`else
    assign w_inj_in = 1'b0;
`endif

    router_pkt_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_LEN),
        .AW     (ROUTER_LEN_W)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_buf_we),
        .i_waddr (r_wr_idx),
        .i_wdata (pl_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    // Handshakes: a payload byte moves on a rising edge with pl_valid && pl_ready;
    // an output byte moves on a rising edge with busy == 0 while in HDR/PAY/PAR.
    always_comb begin
        w_state     = r_state;
        w_data      = r_data;
        w_pkt_valid = r_pkt_valid;
        w_done      = 1'b0;
        w_cfg_err   = 1'b0;
        w_len       = r_len;
        w_dest      = r_dest;
        w_wr_idx    = r_wr_idx;
        w_rd_idx    = r_rd_idx;
        w_gap_cnt   = r_gap_cnt;
        w_parity    = r_parity;
        w_inj       = r_inj;
        w_buf_we    = 1'b0;
        w_rd_addr   = '0;
        case (r_state)
            IDLE: begin
                w_data      = '0;
                w_pkt_valid = 1'b0;
                if (start) begin
                    if (dest == ROUTER_ILLEGAL_DEST || len == '0) begin
                        w_cfg_err = 1'b1;
                    end else begin
                        w_len    = len;
                        w_dest   = dest;
                        w_inj    = w_inj_in;
                        w_parity = make_header(len, dest);
                        w_wr_idx = '0;
                        w_state  = LOAD;
                    end
                end
            end
            LOAD: begin
                if (pl_valid) begin
                    w_buf_we = 1'b1;
                    w_parity = r_parity ^ pl_data;
                    if (r_wr_idx == r_len - 6'd1) begin
                        w_data      = make_header(r_len, r_dest);
                        w_pkt_valid = 1'b1;
                        w_state     = HDR;
                    end else begin
                        w_wr_idx = r_wr_idx + 6'd1;
                    end
                end
            end
            HDR: begin
                w_rd_addr = '0;
                if (!busy) begin
                    w_data   = w_rd_data;
                    w_rd_idx = '0;
                    w_state  = PAY;
                end
            end
            PAY: begin
                // Look one byte ahead so the next payload byte is ready at the transfer edge.
                w_rd_addr = r_rd_idx + 6'd1;
                if (!busy) begin
                    if (r_rd_idx == r_len - 6'd1) begin
                        w_data      = r_inj ? ~r_parity : r_parity;
                        w_pkt_valid = 1'b0;
                        w_state     = PAR;
                    end else begin
                        w_data   = w_rd_data;
                        w_rd_idx = r_rd_idx + 6'd1;
                    end
                end
            end
            PAR: begin
                if (!busy) begin
                    w_done    = 1'b1;
                    w_data    = '0;
                    w_gap_cnt = '0;
                    w_state   = (IDLE_GAP == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (r_gap_cnt == 4'(IDLE_GAP - 1)) begin
                    w_state = IDLE;
                end else begin
                    w_gap_cnt = r_gap_cnt + 4'd1;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_pkt_valid <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_len       <= '0;
            r_dest      <= '0;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_gap_cnt   <= '0;
            r_parity    <= '0;
            r_inj       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_data      <= w_data;
            r_pkt_valid <= w_pkt_valid;
            r_done      <= w_done;
            r_cfg_err   <= w_cfg_err;
            r_len       <= w_len;
            r_dest      <= w_dest;
            r_wr_idx    <= w_wr_idx;
            r_rd_idx    <= w_rd_idx;
            r_gap_cnt   <= w_gap_cnt;
            r_parity    <= w_parity;
            r_inj       <= w_inj;
        end
    end

    assign ready     = (r_state == IDLE) && rst;
    assign pl_ready  = (r_state == LOAD);
    assign data      = r_data;
    assign pkt_valid = r_pkt_valid;
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;
    assign dbg_state = r_state;

endmodule
